instruction_mem_loader: RTL and testbench
=========================================

# instruction_mem_loader

Writer-side companion to the instruction memory: accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and issues single-cycle word writes at sequential word-aligned byte addresses starting at 0. Sits between a host/boot byte source and the instruction memory write port, so programs can be loaded at run time instead of only through initialisation.

## Interface
- DEPTH, 128, number of instruction words (word index = MemAddress[8:2])
- ADDR_W, 32, MemAddress width
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin a load; sampled only in IDLE
- WordCount  in  8  words to load; latched on Start
- ByteIn  in  8  stream byte
- ByteValid  in  1  ByteIn valid
- ByteReady  out  1  loader accepts a byte this cycle
- MemWrite  out  1  one-cycle write strobe
- MemAddress  out  ADDR_W  byte address, always a multiple of 4
- MemWriteData  out  32  packed instruction word
- Busy  out  1  high from the cycle after Start until Done
- Done  out  1  one-cycle pulse at end of load

## Operation
- States: IDLE, ASSEMBLE, WRITE, DONE.
- IDLE: ByteReady=0. On Start=1, latch count = min(WordCount, DEPTH), clear word index and byte count; go to DONE if count==0, else ASSEMBLE.
- ASSEMBLE: ByteReady=1. Each handshake (ByteValid & ByteReady) shifts word <= {word[23:0], ByteIn}, byte count +1. On the 4th byte go to WRITE.
- WRITE: ByteReady=0, MemWrite=1, MemAddress=index*4, MemWriteData=word. Next: index+1; DONE if index+1==count, else ASSEMBLE with byte count 0.
- DONE: Done=1, Busy=0 in this cycle; return to IDLE.
- Start outside IDLE is ignored. ByteValid with ByteReady=0 consumes nothing.
- WordCount > DEPTH clamps to DEPTH; the last address written is (DEPTH-1)*4 = 508 and the index never wraps.
- Reset (any state): state IDLE, partial word and counters discarded, all outputs 0.

## Timing
- Reset values: ByteReady=0, MemWrite=0, MemAddress=0, MemWriteData=0, Busy=0, Done=0.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Start at edge T: ASSEMBLE (ByteReady=1, Busy=1) from T+1.
- 4th byte accepted at edge N: MemWrite high during cycle N+1..N+2 (exactly one cycle); ByteReady low in that cycle; next byte can be accepted at edge N+2.
- Peak throughput: 1 word per 5 cycles with ByteValid held high.
- Final write cycle is followed directly by exactly one Done cycle; Start is accepted again the cycle after Done.
- count==0: Done one cycle after Start, no MemWrite.

## Structure
- Package instruction_loader_pkg: DEPTH default, state enum (IDLE/ASSEMBLE/WRITE/DONE), BYTES_PER_WORD=4 constant.
- Sub-module byte_packer: 32-bit shift register plus 2-bit byte counter with clear/shift enables and a word_full flag; the top level owns the FSM, index counter and memory-port outputs.

## Test plan
- Load 3 words, bytes 00 00 00 00 / 00 00 00 03 / 00 00 00 06, ByteValid always high -> writes (addr 0, data 0), (4, 3), (8, 6), 5 cycles apart; Done one cycle after the last write; the memory then reads back i*3 at indices 0..2.
- Same load with ByteValid low on alternate cycles -> identical writes, only delayed; no byte lost or duplicated; ByteReady low in every WRITE cycle.
- WordCount=0 -> Done the cycle after Start, MemWrite never asserted, ByteReady never asserted.
- WordCount=200, 512 bytes streamed -> 128 writes, last at address 508, then Done; ByteReady stays 0 afterwards and further bytes are ignored.
- Reset low after 2 bytes of word 1 -> all outputs 0 immediately; new Start with 1 word 12 34 56 78 -> single write (0, 0x12345678).
- Start pulsed again mid-load -> ignored; load completes with the original count.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared constants and state encoding for the instruction memory loader.
package instruction_loader_pkg;

    localparam int unsigned DEPTH_DEFAULT  = 128;
    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSEMBLE = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/instruction_mem_loader_byte_packer.sv
// Big-endian byte-to-word shift register with a byte counter; flags the byte that completes a word.
module byte_packer
    import instruction_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_c_o
);

    logic [WORD_W-1:0] word_q;
    logic [BCNT_W-1:0] cnt_q;

    // High on the handshake that delivers the last byte of a word.
    assign word_full_c_o = shift_i && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
    assign word_o        = word_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            word_q <= {word_q[WORD_W-BYTE_W-1:0], byte_i};
            cnt_q  <= cnt_q + BCNT_W'(1);
        end
    end

endmodule

// File: rtl/instruction_mem_loader.sv
// Streams bytes into 32-bit words and writes them to sequential word addresses of the instruction memory.
module instruction_mem_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [CNT_W-1:0]  WordCount,
    input  logic [BYTE_W-1:0] ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [WORD_W-1:0] MemWriteData,
    output logic              Busy,
    output logic              Done
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  index_q, index_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q, ready_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              clr;
    logic              shift;
    logic              word_full;
    logic [CNT_W-1:0]  count_clamped;
    logic [CNT_W-1:0]  index_inc;

    assign shift         = ready_q && ByteValid;
    assign count_clamped = (32'(WordCount) > DEPTH) ? CNT_W'(DEPTH) : WordCount;
    assign index_inc     = index_q + CNT_W'(1);

    byte_packer u_packer (
        .clk_i         (Clk),
        .rst_ni        (Reset),
        .clr_i         (clr),
        .shift_i       (shift),
        .byte_i        (ByteIn),
        .word_o        (MemWriteData),
        .word_full_c_o (word_full)
    );

    // Next-state logic; outputs are registered copies decoded from the next state.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        addr_d  = addr_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    count_d = count_clamped;
                    index_d = '0;
                    clr     = 1'b1;
                    state_d = (count_clamped == '0) ? ST_DONE : ST_ASSEMBLE;
                end
            end
            ST_ASSEMBLE: begin
                if (word_full) begin
                    addr_d  = ADDR_W'({index_q, 2'b00});
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                index_d = index_inc;
                state_d = (index_inc == count_q) ? ST_DONE : ST_ASSEMBLE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_ASSEMBLE);
        write_d = (state_d == ST_WRITE);
        busy_d  = (state_d == ST_ASSEMBLE) || (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            index_q <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ByteReady  = ready_q;
    assign MemWrite   = write_q;
    assign MemAddress = addr_q;
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_instruction_mem_loader.sv
// Directed self-checking bench for instruction_mem_loader.
module tb_instruction_mem_loader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  WordCount;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        MemWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        Busy;
    logic        Done;

    instruction_mem_loader #(.DEPTH(128), .ADDR_W(32)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .WordCount    (WordCount),
        .ByteIn       (ByteIn),
        .ByteValid    (ByteValid),
        .ByteReady    (ByteReady),
        .MemWrite     (MemWrite),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          ready_in_write = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    logic [31:0] mem[128];
    logic [7:0]  tx_q[$];

    always @(posedge Clk) cyc <= cyc + 1;

    // Write-port monitor acting as the instruction memory.
    always @(negedge Clk) begin
        if (MemWrite) begin
            wr_addr.push_back(MemAddress);
            wr_data.push_back(MemWriteData);
            wr_cyc.push_back(cyc);
            mem[MemAddress[8:2]] <= MemWriteData;
            if (ByteReady) ready_in_write <= ready_in_write + 1;
        end
        if (Done) done_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_load(input logic [7:0] wc);
        @(negedge Clk);
        Start     = 1'b1;
        WordCount = wc;
        @(negedge Clk);
        Start     = 1'b0;
    endtask

    // Offer every byte of tx_q; gappy drops ByteValid on alternate cycles.
    task automatic stream(input bit gappy);
        int sent  = 0;
        int guard = 0;
        while (sent < tx_q.size() && guard < 5000) begin
            @(negedge Clk);
            ByteValid = !gappy || (guard % 2 == 1);
            ByteIn    = tx_q[sent];
            if (ByteValid && ByteReady) sent++;
            guard++;
        end
        @(negedge Clk);
        ByteValid = 1'b0;
        check("stream_bytes_accepted", 32'(sent), 32'(tx_q.size()));
    endtask

    task automatic wait_done(input string tag);
        int n0 = done_cyc.size();
        int g  = 0;
        while (done_cyc.size() == n0 && g < 2000) begin
            @(negedge Clk);
            g++;
        end
        @(negedge Clk);
        check({tag, "_done_seen"}, 32'(done_cyc.size() - n0), 32'd1);
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b;
        int extra_ready;
        logic [7:0] iv;
        Reset = 1'b0; Start = 1'b0; WordCount = '0; ByteIn = '0; ByteValid = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_ready", 32'(ByteReady), 0);
        check("rst_write", 32'(MemWrite), 0);
        check("rst_addr", MemAddress, 0);
        check("rst_data", MemWriteData, 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        Reset = 1'b1;
        @(negedge Clk);

        // Three words, ByteValid held high.
        b = wr_addr.size();
        tx_q = {};
        for (int i = 0; i < 3; i++) push_word(32'(i * 3));
        start_load(8'd3);
        check("a_busy_after_start", 32'(Busy), 1);
        check("a_ready_after_start", 32'(ByteReady), 1);
        stream(1'b0);
        wait_done("a");
        check("a_nwrites", 32'(wr_addr.size() - b), 3);
        for (int i = 0; i < 3; i++) begin
            check("a_addr", wr_addr[b + i], 32'(4 * i));
            check("a_data", wr_data[b + i], 32'(3 * i));
            check("a_readback", mem[i], 32'(3 * i));
        end
        check("a_spacing1", 32'(wr_cyc[b + 1] - wr_cyc[b]), 5);
        check("a_spacing2", 32'(wr_cyc[b + 2] - wr_cyc[b + 1]), 5);
        check("a_done_after_write", 32'(done_cyc[done_cyc.size() - 1] - wr_cyc[b + 2]), 1);
        check("a_busy_idle", 32'(Busy), 0);

        // Same load with ByteValid low on alternate cycles.
        for (int i = 0; i < 3; i++) mem[i] = 32'hDEAD_BEEF;
        b = wr_addr.size();
        start_load(8'd3);
        stream(1'b1);
        wait_done("b");
        check("b_nwrites", 32'(wr_addr.size() - b), 3);
        for (int i = 0; i < 3; i++) begin
            check("b_addr", wr_addr[b + i], 32'(4 * i));
            check("b_data", wr_data[b + i], 32'(3 * i));
            check("b_readback", mem[i], 32'(3 * i));
        end
        check("b_ready_in_write", 32'(ready_in_write), 0);

        // WordCount of zero.
        b = wr_addr.size();
        start_load(8'd0);
        check("c_done", 32'(Done), 1);
        check("c_ready", 32'(ByteReady), 0);
        check("c_busy", 32'(Busy), 0);
        @(negedge Clk);
        check("c_done_one_cycle", 32'(Done), 0);
        check("c_ready_after", 32'(ByteReady), 0);
        check("c_nwrites", 32'(wr_addr.size() - b), 0);

        // WordCount above DEPTH clamps to 128 words.
        b = wr_addr.size();
        tx_q = {};
        for (int i = 0; i < 128; i++) begin
            iv = 8'(i);
            push_word({iv, 8'h5A, ~iv, 8'hC3});
        end
        start_load(8'd200);
        stream(1'b0);
        wait_done("d");
        check("d_nwrites", 32'(wr_addr.size() - b), 128);
        for (int i = 0; i < 128; i++) begin
            iv = 8'(i);
            check("d_addr", wr_addr[b + i], 32'(4 * i));
            check("d_data", wr_data[b + i], {iv, 8'h5A, ~iv, 8'hC3});
        end
        check("d_last_addr", wr_addr[wr_addr.size() - 1], 32'd508);
        check("d_done_after_write",
              32'(done_cyc[done_cyc.size() - 1] - wr_cyc[wr_cyc.size() - 1]), 1);
        extra_ready = 0;
        b = wr_addr.size();
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            ByteValid = 1'b1;
            ByteIn    = 8'hEE;
            if (ByteReady) extra_ready++;
        end
        @(negedge Clk);
        ByteValid = 1'b0;
        check("d_ready_after_done", 32'(extra_ready), 0);
        check("d_no_extra_writes", 32'(wr_addr.size() - b), 0);

        // Reset mid-word discards the partial word; then a single-word load.
        tx_q = {8'hAA, 8'hBB};
        start_load(8'd2);
        stream(1'b0);
        Reset = 1'b0;
        #1;
        check("e_rst_ready", 32'(ByteReady), 0);
        check("e_rst_write", 32'(MemWrite), 0);
        check("e_rst_addr", MemAddress, 0);
        check("e_rst_data", MemWriteData, 0);
        check("e_rst_busy", 32'(Busy), 0);
        check("e_rst_done", 32'(Done), 0);
        @(negedge Clk);
        Reset = 1'b1;
        b = wr_addr.size();
        tx_q = {};
        push_word(32'h1234_5678);
        start_load(8'd1);
        stream(1'b0);
        wait_done("e");
        check("e_nwrites", 32'(wr_addr.size() - b), 1);
        check("e_addr", wr_addr[b], 32'd0);
        check("e_data", wr_data[b], 32'h1234_5678);

        // Start pulsed mid-load is ignored.
        b = wr_addr.size();
        tx_q = {8'h11, 8'h22, 8'h33};
        start_load(8'd2);
        stream(1'b0);
        Start     = 1'b1;
        WordCount = 8'd5;
        @(negedge Clk);
        Start     = 1'b0;
        tx_q = {8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        stream(1'b0);
        wait_done("f");
        check("f_nwrites", 32'(wr_addr.size() - b), 2);
        check("f_data0", wr_data[b], 32'h1122_3344);
        check("f_data1", wr_data[b + 1], 32'h5566_7788);
        check("f_addr1", wr_addr[b + 1], 32'd4);
        check("f_busy_idle", 32'(Busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
